// File: rtl/data_mem_amo_slave_pkg.sv
// Shared pipeline definitions for the c2c_data path.
// amo_funct5_e carries the RV A-extension funct5 encodings. The LSU decoder
// and this slave both use it.
package data_mem_amo_slave_pkg;

  typedef enum logic [4:0] {
    AMO_ADD  = 5'b00000,
    AMO_SWAP = 5'b00001,
    AMO_LR   = 5'b00010,
    AMO_SC   = 5'b00011,
    AMO_XOR  = 5'b00100,
    AMO_OR   = 5'b01000,
    AMO_AND  = 5'b01100,
    AMO_MIN  = 5'b10000,
    AMO_MAX  = 5'b10100,
    AMO_MINU = 5'b11000,
    AMO_MAXU = 5'b11100
  } amo_funct5_e;

endpackage

// File: rtl/data_mem_amo_slave_amo_alu.sv
// amo_alu: combinational read-modify-write function for AMOs.
// Ports:
//   op        in   funct5 of the AMO
//   old_word  in   word read from memory
//   operand   in   data_w captured at acceptance
//   new_word  out  word to write back
//   wr_en     out  1 when op is a read-modify-write op (LR/SC/undefined -> 0)
module amo_alu
  import data_mem_amo_slave_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  amo_funct5_e      op,
  input  logic [XLEN-1:0]  old_word,
  input  logic [XLEN-1:0]  operand,
  output logic [XLEN-1:0]  new_word,
  output logic             wr_en
);

  logic signed [XLEN-1:0] old_s;
  logic signed [XLEN-1:0] opnd_s;

  assign old_s  = old_word;
  assign opnd_s = operand;

  // Min/max pick the operand only on a strict win, so equal operands keep old.
  always_comb begin
    new_word = old_word;
    wr_en    = 1'b1;
    case (op)
      AMO_ADD:  new_word = old_word + operand;
      AMO_SWAP: new_word = operand;
      AMO_XOR:  new_word = old_word ^ operand;
      AMO_OR:   new_word = old_word | operand;
      AMO_AND:  new_word = old_word & operand;
      AMO_MIN:  new_word = (opnd_s < old_s) ? operand : old_word;
      AMO_MAX:  new_word = (opnd_s > old_s) ? operand : old_word;
      AMO_MINU: new_word = (operand < old_word) ? operand : old_word;
      AMO_MAXU: new_word = (operand > old_word) ? operand : old_word;
      default:  wr_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_mem_amo_slave.sv
// data_mem_amo_slave: c2c_data bus slave behind the LSU. It serves loads,
// byte-enable stores, LR/SC and AMOs from a single-port word SRAM. It holds one
// LR/SC reservation.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   data_re / data_we     read / write request, held until data_ack
//   atomic, amo_op        request is AMO/LR/SC, with its funct5
//   data_sel              byte enables for plain writes
//   data_addr, data_w     byte address (word-aligned use), write data / operand
//   data_ack, data_r      one-cycle completion pulse and its read data
module data_mem_amo_slave
  import data_mem_amo_slave_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                data_re,
  input  logic                data_we,
  input  logic                atomic,
  input  logic [4:0]          amo_op,
  input  logic [XLEN/8-1:0]   data_sel,
  input  logic [XLEN-1:0]     data_addr,
  input  logic [XLEN-1:0]     data_w,
  output logic                data_ack,
  output logic [XLEN-1:0]     data_r
);

  localparam int NB    = XLEN / 8;
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {IDLE, RD, AMO_RD, AMO_WR, WR, DONE} state_e;

  state_e            state_q, state_d;
  logic              run_q;
  logic              ack_q, ack_d;
  logic [XLEN-1:0]   data_r_q, data_r_d;
  logic              rsv_vld_q, rsv_vld_d;
  logic [IDX_W-1:0]  rsv_idx_q, rsv_idx_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  amo_funct5_e       op_q, op_d;
  logic              wr_fail_q, wr_fail_d;

  logic [XLEN-1:0]   mem [DEPTH_WORDS];
  logic [XLEN-1:0]   rdata_q;
  logic              mem_re, mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [NB-1:0]     mem_be;
  logic [XLEN-1:0]   mem_wdata;

  amo_funct5_e       req_op;
  logic [IDX_W-1:0]  req_idx;
  logic              rsv_hit;
  logic [XLEN-1:0]   alu_new;
  logic              alu_wr;
  logic              unused_addr;

  // Upper address bits alias onto the array; byte offset is ignored.
  assign req_idx     = data_addr[IDX_W+1:2];
  assign unused_addr = ^{data_addr[XLEN-1:IDX_W+2], data_addr[1:0]};
  assign req_op      = amo_funct5_e'(amo_op);
  assign rsv_hit     = rsv_vld_q && (rsv_idx_q == req_idx);
  assign data_ack    = ack_q;
  assign data_r      = data_r_q;

  amo_alu #(.XLEN(XLEN)) u_amo_alu (
    .op       (op_q),
    .old_word (rdata_q),
    .operand  (opnd_q),
    .new_word (alu_new),
    .wr_en    (alu_wr)
  );

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    data_r_d  = data_r_q;
    rsv_vld_d = rsv_vld_q;
    rsv_idx_d = rsv_idx_q;
    idx_d     = idx_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    wr_fail_d = wr_fail_q;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = idx_q;
    mem_be    = '1;
    mem_wdata = alu_new;
    case (state_q)
      IDLE: begin
        mem_idx = req_idx;
        idx_d   = req_idx;
        opnd_d  = data_w;
        op_d    = req_op;
        // run_q keeps the slave idle for the first edge after reset release.
        if (run_q) begin
          if (atomic) begin
            if (req_op == AMO_LR) begin
              mem_re    = 1'b1;
              rsv_vld_d = 1'b1;
              rsv_idx_d = req_idx;
              state_d   = RD;
            end else if (req_op == AMO_SC) begin
              mem_we    = rsv_hit;
              mem_wdata = data_w;
              wr_fail_d = !rsv_hit;
              rsv_vld_d = 1'b0;
              state_d   = WR;
            end else begin
              if (rsv_hit) rsv_vld_d = 1'b0;
              state_d = AMO_RD;
            end
          end else if (data_we) begin
            mem_we    = |data_sel;
            mem_be    = data_sel;
            mem_wdata = data_w;
            wr_fail_d = 1'b0;
            if (rsv_hit && (|data_sel)) rsv_vld_d = 1'b0;
            state_d   = WR;
          end else if (data_re) begin
            mem_re  = 1'b1;
            state_d = RD;
          end
        end
      end
      RD: begin
        ack_d    = 1'b1;
        data_r_d = rdata_q;
        state_d  = DONE;
      end
      AMO_RD: begin
        mem_re  = 1'b1;
        state_d = AMO_WR;
      end
      AMO_WR: begin
        mem_we   = alu_wr;
        ack_d    = 1'b1;
        data_r_d = rdata_q;
        state_d  = DONE;
      end
      WR: begin
        ack_d    = 1'b1;
        data_r_d = {{(XLEN-1){1'b0}}, wr_fail_q};
        state_d  = DONE;
      end
      // Ack is visible in this cycle while the master still holds the request;
      // staying out of IDLE here prevents accepting it a second time.
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      run_q     <= 1'b0;
      ack_q     <= 1'b0;
      data_r_q  <= '0;
      rsv_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      ack_q     <= ack_d;
      data_r_q  <= data_r_d;
      rsv_vld_q <= rsv_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    rsv_idx_q <= rsv_idx_d;
    idx_q     <= idx_d;
    opnd_q    <= opnd_d;
    op_q      <= op_d;
    wr_fail_q <= wr_fail_d;
  end

  // Single-port SRAM: registered read, byte-enable write. run_q is low during
  // reset, so no write can land once rst_n has fallen.
  always_ff @(posedge clk) begin
    if (mem_re) rdata_q <= mem[mem_idx];
    for (int b = 0; b < NB; b++) begin
      if (mem_we && run_q && mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  a_ack_pulse: assert property (@(posedge clk) disable iff (!rst_n) ack_q |=> !ack_q);

  a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q inside {RD, AMO_RD, AMO_WR, WR}) |->
      $stable({data_re, data_we, atomic, amo_op, data_sel, data_addr, data_w}));

endmodule

// File: tb/tb_data_mem_amo_slave.sv
module tb_data_mem_amo_slave;
  import data_mem_amo_slave_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        data_re, data_we, atomic;
  logic [4:0]  amo_op;
  logic [3:0]  data_sel;
  logic [31:0] data_addr, data_w;
  logic        data_ack;
  logic [31:0] data_r;

  data_mem_amo_slave #(.XLEN(32), .DEPTH_WORDS(1024)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_re   (data_re),
    .data_we   (data_we),
    .atomic    (atomic),
    .amo_op    (amo_op),
    .data_sel  (data_sel),
    .data_addr (data_addr),
    .data_w    (data_w),
    .data_ack  (data_ack),
    .data_r    (data_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        re, we, at;
    logic [4:0]  op;
    logic [3:0]  sel;
    logic [31:0] addr, wd, exp;
    logic        chk;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t v_wr(string n, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    vec_t v;
    v.name = n; v.re = 1'b0; v.we = 1'b1; v.at = 1'b0; v.op = 5'd0;
    v.sel = s; v.addr = a; v.wd = d; v.exp = 32'd0; v.chk = 1'b0;
    return v;
  endfunction

  function automatic vec_t v_rd(string n, logic [31:0] a, logic [31:0] e);
    vec_t v;
    v.name = n; v.re = 1'b1; v.we = 1'b0; v.at = 1'b0; v.op = 5'd0;
    v.sel = 4'h0; v.addr = a; v.wd = 32'd0; v.exp = e; v.chk = 1'b1;
    return v;
  endfunction

  function automatic vec_t v_amo(string n, logic [4:0] o, logic [31:0] a, logic [31:0] d,
                                 logic [31:0] e);
    vec_t v;
    v.name = n; v.re = 1'b0; v.we = 1'b0; v.at = 1'b1; v.op = o;
    v.sel = 4'hF; v.addr = a; v.wd = d; v.exp = e; v.chk = 1'b1;
    return v;
  endfunction

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, exp);
  endtask

  task automatic drive(input vec_t v);
    data_re = v.re; data_we = v.we; atomic = v.at; amo_op = v.op;
    data_sel = v.sel; data_addr = v.addr; data_w = v.wd;
  endtask

  task automatic idle_bus();
    data_re = 1'b0; data_we = 1'b0; atomic = 1'b0;
  endtask

  // Drive at a negedge while the slave is idle, so the next posedge accepts.
  // cyc = 1 is the cycle right after the acceptance edge.
  task automatic run_req(input vec_t v, output logic [31:0] rdata, output int cyc,
                         output logic got);
    @(negedge clk);
    drive(v);
    @(posedge clk); #1;
    cyc = 1; got = 1'b0; rdata = 32'hx;
    while (!got && cyc < 12) begin
      if (data_ack) begin
        got = 1'b1;
        rdata = data_r;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    idle_bus();
    @(posedge clk);
  endtask

  task automatic apply(input vec_t v, output int cyc);
    logic [31:0] rd;
    logic        got;
    run_req(v, rd, cyc, got);
    check({v.name, " ack"}, {31'd0, got}, 32'd1);
    if (v.chk) check(v.name, rd, v.exp);
  endtask

  initial begin
    int          cyc;
    int          acks, first_ack, second_ack, cnt;
    logic        prev_ack, dbl;
    logic [31:0] r1, r2;

    rst_n = 1'b0;
    data_re = 1'b0; data_we = 1'b0; atomic = 1'b0; amo_op = 5'd0;
    data_sel = 4'h0; data_addr = 32'd0; data_w = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ack", {31'd0, data_ack}, 32'd0);
    check("reset data_r", data_r, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Latency: plain write and read ack in cycle 2, AMO acks in cycle 3.
    apply(v_wr("wr deadbeef", 32'h40, 32'hDEADBEEF, 4'hF), cyc);
    check("wr latency", cyc, 2);
    apply(v_rd("rd deadbeef", 32'h40, 32'hDEADBEEF), cyc);
    check("rd latency", cyc, 2);
    apply(v_wr("wr amo init", 32'h10, 32'd5, 4'hF), cyc);
    apply(v_amo("amoadd wrap", AMO_ADD, 32'h10, 32'hFFFFFFFF, 32'd5), cyc);
    check("amo latency", cyc, 3);

    vecs.push_back(v_rd("rd add result", 32'h10, 32'd4));
    vecs.push_back(v_amo("amomin", AMO_MIN, 32'h10, 32'h80000000, 32'd4));
    vecs.push_back(v_rd("rd min result", 32'h10, 32'h80000000));
    vecs.push_back(v_amo("amominu", AMO_MINU, 32'h10, 32'd1, 32'h80000000));
    vecs.push_back(v_rd("rd minu result", 32'h10, 32'd1));
    vecs.push_back(v_amo("amomax equal", AMO_MAX, 32'h10, 32'd1, 32'd1));
    vecs.push_back(v_amo("amomaxu", AMO_MAXU, 32'h10, 32'hFFFFFFFF, 32'd1));
    vecs.push_back(v_amo("amomax signed", AMO_MAX, 32'h10, 32'd5, 32'hFFFFFFFF));
    vecs.push_back(v_amo("amoswap", AMO_SWAP, 32'h10, 32'h0F0F0F0F, 32'd5));
    vecs.push_back(v_amo("amoxor", AMO_XOR, 32'h10, 32'hFF00FF00, 32'h0F0F0F0F));
    vecs.push_back(v_amo("amoor", AMO_OR, 32'h10, 32'h0000000F, 32'hF00FF00F));
    vecs.push_back(v_amo("amoand", AMO_AND, 32'h10, 32'h0000FFFF, 32'hF00FF00F));
    vecs.push_back(v_amo("amo undefined", 5'b00101, 32'h10, 32'hFFFFFFFF, 32'h0000F00F));
    vecs.push_back(v_rd("rd after undef", 32'h10, 32'h0000F00F));
    vecs.push_back(v_wr("wr full", 32'h40, 32'h11223344, 4'hF));
    vecs.push_back(v_wr("wr sel 0101", 32'h40, 32'hAABBCCDD, 4'b0101));
    vecs.push_back(v_rd("rd byte merge", 32'h40, 32'h11BB33DD));
    vecs.push_back(v_wr("wr alias", 32'h1040, 32'hCAFEF00D, 4'hF));
    vecs.push_back(v_rd("rd alias", 32'h40, 32'hCAFEF00D));
    vecs.push_back(v_wr("wr sel none", 32'h40, 32'hFFFFFFFF, 4'h0));
    vecs.push_back(v_rd("rd sel none", 32'h40, 32'hCAFEF00D));
    vecs.push_back(v_wr("wr init 20", 32'h20, 32'd0, 4'hF));
    vecs.push_back(v_amo("lr 20", AMO_LR, 32'h20, 32'd0, 32'd0));
    vecs.push_back(v_amo("sc ok", AMO_SC, 32'h20, 32'd7, 32'd0));
    vecs.push_back(v_rd("rd sc ok", 32'h20, 32'd7));
    vecs.push_back(v_amo("sc again", AMO_SC, 32'h20, 32'd9, 32'd1));
    vecs.push_back(v_rd("rd sc again", 32'h20, 32'd7));
    vecs.push_back(v_amo("lr 20 b", AMO_LR, 32'h20, 32'd0, 32'd7));
    vecs.push_back(v_wr("st byte 20", 32'h20, 32'h000000AA, 4'b0001));
    vecs.push_back(v_amo("sc after st", AMO_SC, 32'h20, 32'h55, 32'd1));
    vecs.push_back(v_rd("rd sc after st", 32'h20, 32'h000000AA));
    vecs.push_back(v_wr("wr init 24", 32'h24, 32'h12345678, 4'hF));
    vecs.push_back(v_amo("lr 20 c", AMO_LR, 32'h20, 32'd0, 32'h000000AA));
    vecs.push_back(v_amo("sc wrong addr", AMO_SC, 32'h24, 32'h99, 32'd1));
    vecs.push_back(v_rd("rd 24 kept", 32'h24, 32'h12345678));
    vecs.push_back(v_amo("lr 20 d", AMO_LR, 32'h20, 32'd0, 32'h000000AA));
    vecs.push_back(v_amo("amoadd rsv", AMO_ADD, 32'h20, 32'd1, 32'h000000AA));
    vecs.push_back(v_amo("sc after amo", AMO_SC, 32'h20, 32'd0, 32'd1));
    vecs.push_back(v_rd("rd after amo", 32'h20, 32'h000000AB));
    begin
      vec_t rw;
      rw = v_wr("re+we is write", 32'h44, 32'h01020304, 4'hF);
      rw.re = 1'b1;
      vecs.push_back(rw);
    end
    vecs.push_back(v_rd("rd re+we", 32'h47, 32'h01020304));
    vecs.push_back(v_wr("wr init 30", 32'h30, 32'h00000010, 4'hF));

    foreach (vecs[i]) apply(vecs[i], cyc);

    // Reset while the AMO is in its read phase: no ack, no write.
    @(negedge clk);
    drive(v_amo("amo reset", AMO_ADD, 32'h30, 32'h100, 32'd0));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("ack after reset", {31'd0, data_ack}, 32'd0);
    check("data_r after reset", data_r, 32'd0);
    idle_bus();
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    apply(v_rd("rd after reset", 32'h30, 32'h00000010), cyc);

    // Back-to-back: the second request is presented the moment the first acks.
    @(negedge clk);
    drive(v_rd("b2b a", 32'h44, 32'd0));
    acks = 0; first_ack = 0; second_ack = 0; prev_ack = 1'b0; dbl = 1'b0;
    r1 = 32'd0; r2 = 32'd0;
    for (cnt = 1; cnt <= 20; cnt++) begin
      @(posedge clk); #1;
      if (data_ack && prev_ack) dbl = 1'b1;
      prev_ack = data_ack;
      if (data_ack) begin
        acks++;
        if (acks == 1) begin
          first_ack = cnt; r1 = data_r;
          drive(v_rd("b2b b", 32'h10, 32'd0));
        end else if (acks == 2) begin
          second_ack = cnt; r2 = data_r;
          idle_bus();
        end
      end
    end
    check("b2b ack count", acks, 2);
    check("b2b no double ack", {31'd0, dbl}, 32'd0);
    check("b2b ack spacing", second_ack - first_ack, 3);
    check("b2b data a", r1, 32'h01020304);
    check("b2b data b", r2, 32'h0000F00F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
